// File: rtl/enable_gen_if.sv
// Control/strobe bundle between a burst controller and enable_gen.
// The master requests bursts; the slave (enable_gen) returns the strobe and status.
interface enable_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic                  abort;
  logic [DATA_WIDTH-1:0] period;
  logic [DATA_WIDTH-1:0] pulses;
  logic                  en_out;
  logic                  busy;
  logic                  done;

  modport master (
    output start, abort, period, pulses,
    input  en_out, busy, done
  );

  modport slave (
    input  start, abort, period, pulses,
    output en_out, busy, done
  );
endinterface

// File: rtl/enable_gen.sv
// Programmable enable-strobe generator: emits a burst of single-cycle pulses at a
// programmed spacing (or continuously) for a downstream counter's enable input.
module enable_gen #(
  parameter int DATA_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  enable_gen_if.slave  bus
);

  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] per_q, per_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] ph_q, ph_d;
  logic                  en_out_q, en_out_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  pulse_now;
  logic                  last_pulse;
  logic [DATA_WIDTH-1:0] ph_inc;

  // The phase counter is zero exactly in the cycles that carry a pulse.
  assign pulse_now  = (ph_q == '0);
  assign last_pulse = pulse_now && (rem_q == ONE);
  assign ph_inc     = (ph_q == (per_q - ONE)) ? '0 : (ph_q + ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      per_q    <= '0;
      rem_q    <= '0;
      ph_q     <= '0;
      en_out_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      rem_q    <= rem_d;
      ph_q     <= ph_d;
      en_out_q <= en_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    rem_d    = rem_q;
    ph_d     = ph_q;
    en_out_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d  = ST_RUN;
          per_d    = (bus.period == '0) ? ONE : bus.period;
          rem_d    = bus.pulses;
          ph_d     = '0;
          en_out_d = 1'b1;
          busy_d   = 1'b1;
        end
      end

      ST_RUN: begin
        if (bus.abort) begin
          // Abort wins even over a final pulse in this cycle: no done.
          state_d = ST_IDLE;
          per_d   = '0;
          rem_d   = '0;
          ph_d    = '0;
        end else if (last_pulse) begin
          state_d = ST_IDLE;
          per_d   = '0;
          rem_d   = '0;
          ph_d    = '0;
          done_d  = 1'b1;
        end else begin
          // rem_q == 0 means continuous mode and is never decremented.
          if (pulse_now && (rem_q != '0)) begin
            rem_d = rem_q - ONE;
          end
          ph_d     = ph_inc;
          en_out_d = (ph_inc == '0);
          busy_d   = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.en_out = en_out_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_enable_gen.sv
// Directed bench for enable_gen: burst timing, degenerate/max period, continuous
// mode with abort, start/abort interactions and asynchronous reset mid-burst.
module tb_enable_gen;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   en_cnt;

  enable_gen_if #(.DATA_WIDTH(8)) bus_if ();

  enable_gen #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream counter (FROM 0, STEP 1) advancing on every edge that samples en_out=1.
  initial en_cnt = 0;
  always @(posedge clk) begin
    if (bus_if.en_out === 1'b1) en_cnt <= en_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a start from IDLE; returns positioned in the first RUN cycle.
  task automatic launch(input logic [7:0] per, input logic [7:0] pul);
    bus_if.period = per;
    bus_if.pulses = pul;
    bus_if.start  = 1'b1;
    step();
    bus_if.start  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.start  = 1'b0;
    bus_if.abort  = 1'b0;
    bus_if.period = 8'd0;
    bus_if.pulses = 8'd0;
    step();
    step();
    checks++;
    if ({bus_if.en_out, bus_if.busy, bus_if.done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs got en/busy/done=%b exp 000",
               {bus_if.en_out, bus_if.busy, bus_if.done});
    end
    rst = 1'b0;
    step();
    checks++;
    if ({bus_if.en_out, bus_if.busy, bus_if.done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release got en/busy/done=%b exp 000",
               {bus_if.en_out, bus_if.busy, bus_if.done});
    end
    $display("test_reset done");
  endtask

  // period=3, pulses=4: pulses in cycles 1,4,7,10; busy 1..10; done in 11.
  task automatic test_burst();
    int base;
    logic exp_en, exp_busy, exp_done;
    base = en_cnt;
    launch(8'd3, 8'd4);
    for (int c = 1; c <= 12; c++) begin
      exp_en   = (c == 1) || (c == 4) || (c == 7) || (c == 10);
      exp_busy = (c <= 10);
      exp_done = (c == 11);
      checks++;
      if ({bus_if.en_out, bus_if.busy, bus_if.done} !== {exp_en, exp_busy, exp_done}) begin
        errors++;
        $display("FAIL burst cycle %0d got en/busy/done=%b exp %b", c,
                 {bus_if.en_out, bus_if.busy, bus_if.done}, {exp_en, exp_busy, exp_done});
      end
      step();
    end
    checks++;
    if (en_cnt - base !== 4) begin
      errors++;
      $display("FAIL burst_count got %0d exp 4", en_cnt - base);
    end
    $display("test_burst period=3 pulses=4 done");
  endtask

  // period=0 behaves as 1: five back-to-back pulses, done in cycle 6.
  task automatic test_degenerate_period();
    int base;
    logic exp_en, exp_done;
    base = en_cnt;
    launch(8'd0, 8'd5);
    for (int c = 1; c <= 7; c++) begin
      exp_en   = (c <= 5);
      exp_done = (c == 6);
      checks++;
      if ({bus_if.en_out, bus_if.busy, bus_if.done} !== {exp_en, exp_en, exp_done}) begin
        errors++;
        $display("FAIL degenerate cycle %0d got en/busy/done=%b exp %b", c,
                 {bus_if.en_out, bus_if.busy, bus_if.done}, {exp_en, exp_en, exp_done});
      end
      if (c == 6) begin
        checks++;
        if (en_cnt - base !== 5) begin
          errors++;
          $display("FAIL degenerate_counter got %0d exp 5", en_cnt - base);
        end
      end
      step();
    end
    $display("test_degenerate_period period=0 pulses=5 done");
  endtask

  // Continuous, period=2: pulses on odd cycles; abort in cycle 14 after 7 pulses.
  task automatic test_continuous_abort();
    int base;
    logic exp_en;
    base = en_cnt;
    launch(8'd2, 8'd0);
    for (int c = 1; c <= 14; c++) begin
      exp_en = (c % 2) == 1;
      checks++;
      if ({bus_if.en_out, bus_if.busy, bus_if.done} !== {exp_en, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL continuous cycle %0d got en/busy/done=%b exp %b", c,
                 {bus_if.en_out, bus_if.busy, bus_if.done}, {exp_en, 1'b1, 1'b0});
      end
      if (c == 14) bus_if.abort = 1'b1;
      step();
    end
    bus_if.abort = 1'b0;
    for (int c = 15; c <= 18; c++) begin
      checks++;
      if ({bus_if.en_out, bus_if.busy, bus_if.done} !== 3'b000) begin
        errors++;
        $display("FAIL continuous_after_abort cycle %0d got en/busy/done=%b exp 000", c,
                 {bus_if.en_out, bus_if.busy, bus_if.done});
      end
      step();
    end
    checks++;
    if (en_cnt - base !== 7) begin
      errors++;
      $display("FAIL continuous_count got %0d exp 7", en_cnt - base);
    end
    $display("test_continuous_abort pulses=7 done");
  endtask

  // Abort in the cycle carrying the final pulse: the pulse is seen, done is not.
  task automatic test_abort_final();
    launch(8'd1, 8'd3);
    step();
    step();
    checks++;
    if ({bus_if.en_out, bus_if.busy} !== 2'b11) begin
      errors++;
      $display("FAIL abort_final_pulse got en/busy=%b exp 11", {bus_if.en_out, bus_if.busy});
    end
    bus_if.abort = 1'b1;
    step();
    bus_if.abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({bus_if.en_out, bus_if.busy, bus_if.done} !== 3'b000) begin
        errors++;
        $display("FAIL abort_final_after cycle %0d got en/busy/done=%b exp 000", c,
                 {bus_if.en_out, bus_if.busy, bus_if.done});
      end
      step();
    end
    $display("test_abort_final done");
  endtask

  task automatic test_start_abort_idle();
    bus_if.period = 8'd1;
    bus_if.pulses = 8'd2;
    bus_if.start  = 1'b1;
    bus_if.abort  = 1'b1;
    step();
    bus_if.start  = 1'b0;
    bus_if.abort  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({bus_if.en_out, bus_if.busy, bus_if.done} !== 3'b000) begin
        errors++;
        $display("FAIL start_abort_idle cycle %0d got en/busy/done=%b exp 000", c,
                 {bus_if.en_out, bus_if.busy, bus_if.done});
      end
      step();
    end
    $display("test_start_abort_idle done");
  endtask

  // period=3 pulses=2; a new start with other settings in cycle 2 must be ignored.
  task automatic test_start_in_run();
    logic exp_en, exp_busy, exp_done;
    launch(8'd3, 8'd2);
    for (int c = 1; c <= 7; c++) begin
      exp_en   = (c == 1) || (c == 4);
      exp_busy = (c <= 4);
      exp_done = (c == 5);
      checks++;
      if ({bus_if.en_out, bus_if.busy, bus_if.done} !== {exp_en, exp_busy, exp_done}) begin
        errors++;
        $display("FAIL start_in_run cycle %0d got en/busy/done=%b exp %b", c,
                 {bus_if.en_out, bus_if.busy, bus_if.done}, {exp_en, exp_busy, exp_done});
      end
      if (c == 2) begin
        bus_if.start  = 1'b1;
        bus_if.period = 8'd1;
        bus_if.pulses = 8'd9;
      end else begin
        bus_if.start  = 1'b0;
      end
      step();
    end
    $display("test_start_in_run done");
  endtask

  task automatic test_async_reset();
    launch(8'd4, 8'd10);
    for (int c = 1; c < 5; c++) step();
    checks++;
    if ({bus_if.en_out, bus_if.busy} !== 2'b11) begin
      errors++;
      $display("FAIL async_pre_reset got en/busy=%b exp 11", {bus_if.en_out, bus_if.busy});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus_if.en_out, bus_if.busy, bus_if.done} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset_immediate got en/busy/done=%b exp 000",
               {bus_if.en_out, bus_if.busy, bus_if.done});
    end
    #2 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if ({bus_if.en_out, bus_if.busy, bus_if.done} !== 3'b000) begin
        errors++;
        $display("FAIL async_after_release cycle %0d got en/busy/done=%b exp 000", c,
                 {bus_if.en_out, bus_if.busy, bus_if.done});
      end
    end
    $display("test_async_reset done");
    test_burst();
  endtask

  // period=255 pulses=2: pulses in cycles 1 and 256, done in 257.
  task automatic test_max_period();
    int base;
    logic exp_en, exp_busy, exp_done;
    base = en_cnt;
    launch(8'd255, 8'd2);
    for (int c = 1; c <= 258; c++) begin
      exp_en   = (c == 1) || (c == 256);
      exp_busy = (c <= 256);
      exp_done = (c == 257);
      checks++;
      if ({bus_if.en_out, bus_if.busy, bus_if.done} !== {exp_en, exp_busy, exp_done}) begin
        errors++;
        $display("FAIL max_period cycle %0d got en/busy/done=%b exp %b", c,
                 {bus_if.en_out, bus_if.busy, bus_if.done}, {exp_en, exp_busy, exp_done});
      end
      step();
    end
    checks++;
    if (en_cnt - base !== 2) begin
      errors++;
      $display("FAIL max_period_count got %0d exp 2", en_cnt - base);
    end
    $display("test_max_period period=255 pulses=2 done");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_burst();
    test_degenerate_period();
    test_continuous_abort();
    test_abort_final();
    test_start_abort_idle();
    test_start_in_run();
    test_async_reset();
    test_max_period();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
